// File: rtl/pwm_pkg.sv
// pwm_pkg: shared encodings and helpers for the PWM carrier/compare generator.
//   count_mode_e : carrier counting mode (COUNT_STOP is the reserved code).
//   mask_mode_e  : which carrier events are masked from shadow reload.
//   pwm_cmp      : channel compare rule, active while counter < compare.
package pwm_pkg;

    typedef enum logic [1:0] {
        COUNT_UP     = 2'b00,
        COUNT_DOWN   = 2'b01,
        COUNT_UPDOWN = 2'b10,
        COUNT_STOP   = 2'b11
    } count_mode_e;

    typedef enum logic [1:0] {
        NO_MASK     = 2'b00,
        MIN_MASK    = 2'b01,
        MAX_MASK    = 2'b10,
        MINMAX_MASK = 2'b11
    } mask_mode_e;

    // Operands are widened to 32 bits by the caller, so counters up to 32 bits wide work.
    function automatic logic pwm_cmp(input logic [31:0] counter, input logic [31:0] cmp);
        return counter < cmp;
    endfunction

endpackage

// File: rtl/pwm_compare_ch.sv
// pwm_compare_ch: one compare channel.
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture cmp_in into the compare shadow at this edge
//   en       : channel active; when low the output register clears
//   cmp_in   : compare request value
//   counter  : registered carrier value
//   pwm      : registered channel output, (counter < shadow), one cycle behind counter
module pwm_compare_ch
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] cmp_in,
    input  logic [CNT_W-1:0] counter,
    output logic             pwm
);

    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic             pwm_q, pwm_d;

    // The output uses the shadow in force during this cycle, before any reload.
    always_comb begin
        cmp_d = load ? cmp_in : cmp_q;
        pwm_d = en ? pwm_cmp(32'(counter), 32'(cmp_q)) : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/pwm_carrier_gen.sv
// pwm_carrier_gen: shadowed PWM carrier (up / down / up-down) with N_CH compare channels.
//   clk, rst    : clock, asynchronous active-high reset
//   en          : run enable; while low all shadows track their requests
//   count_mode  : carrier mode request (shadowed)
//   mask_mode   : reload event masking (live, not shadowed)
//   period      : period request (shadowed)
//   compare     : per-channel compare requests, channel i at [i*CNT_W +: CNT_W]
//   counter     : registered carrier value
//   dir_down    : high while the carrier counts down (direction state)
//   evt_min     : counter == 0 this cycle
//   evt_max     : counter == period shadow this cycle
//   load_strobe : shadows reload at the end of this cycle
//   pwm_out     : registered channel outputs
module pwm_carrier_gen
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int N_CH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            count_mode,
    input  logic [1:0]            mask_mode,
    input  logic [CNT_W-1:0]      period,
    input  logic [N_CH*CNT_W-1:0] compare,
    output logic [CNT_W-1:0]      counter,
    output logic                  dir_down,
    output logic                  evt_min,
    output logic                  evt_max,
    output logic                  load_strobe,
    output logic [N_CH-1:0]       pwm_out
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] per_q, per_d;
    count_mode_e      mode_q, mode_d;

    logic run_c, evt_min_c, evt_max_c, load_c, shadow_load_c;

    // Event decode and reload qualification.
    always_comb begin
        run_c     = en && !rst && (mode_q != COUNT_STOP);
        evt_min_c = run_c && (cnt_q == '0);
        evt_max_c = run_c && (cnt_q == per_q);
        case (mask_mode_e'(mask_mode))
            NO_MASK:  load_c = evt_min_c || evt_max_c;
            MIN_MASK: load_c = evt_max_c;
            MAX_MASK: load_c = evt_min_c;
            default:  load_c = 1'b0;
        endcase
        // Shadows are transparent while disabled.
        shadow_load_c = !en || load_c;
        per_d  = shadow_load_c ? period : per_q;
        mode_d = shadow_load_c ? count_mode_e'(count_mode) : mode_q;
    end

    // Carrier next state, computed from the shadows as they will be after this edge.
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (!en) begin
            cnt_d = (mode_d == COUNT_DOWN) ? per_d : '0;
            dir_d = (mode_d == COUNT_DOWN);
        end else if (mode_q != COUNT_STOP) begin
            case (mode_d)
                COUNT_UP: begin
                    dir_d = 1'b0;
                    cnt_d = (cnt_q >= per_d) ? '0 : cnt_q + ONE;
                end
                COUNT_DOWN: begin
                    dir_d = 1'b1;
                    cnt_d = ((cnt_q == '0) || (cnt_q > per_d)) ? per_d : cnt_q - ONE;
                end
                COUNT_UPDOWN: begin
                    // At zero the carrier always turns upward, whatever the stored direction.
                    if ((cnt_q == '0) || !dir_q) begin
                        if (cnt_q >= per_d) begin
                            if (per_d == '0) begin
                                cnt_d = '0;
                                dir_d = 1'b0;
                            end else begin
                                cnt_d = per_d - ONE;
                                dir_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + ONE;
                            dir_d = 1'b0;
                        end
                    end else if (cnt_q > per_d) begin
                        cnt_d = per_d;
                    end else if (cnt_q == ONE) begin
                        cnt_d = '0;
                        dir_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                default: begin
                    // Entering the reserved mode: hold counter and direction.
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            per_q  <= '0;
            mode_q <= COUNT_UP;
        end else begin
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            per_q  <= per_d;
            mode_q <= mode_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        pwm_compare_ch #(.CNT_W(CNT_W)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .load    (shadow_load_c),
            .en      (run_c),
            .cmp_in  (compare[g*CNT_W +: CNT_W]),
            .counter (cnt_q),
            .pwm     (pwm_out[g])
        );
    end

    assign counter     = cnt_q;
    assign dir_down    = dir_q;
    assign evt_min     = evt_min_c;
    assign evt_max     = evt_max_c;
    assign load_strobe = load_c;

endmodule
